// File: rtl/scan_transfer_scheduler_pkg.sv
// Shared command codes, link command encodings and FSM state type for the
// scanner ping-pong transfer scheduler.
package scan_pkg;

  localparam logic [7:0] CMD_READY = 8'd2;
  localparam logic [7:0] CMD_START = 8'd3;
  localparam logic [7:0] CMD_FULL  = 8'd4;
  localparam logic [7:0] CMD_DATA  = 8'd7;

  localparam logic [1:0] LT_NONE    = 2'b00;
  localparam logic [1:0] LT_START   = 2'b01;
  localparam logic [1:0] LT_RELEASE = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_OVERLAP,
    ST_GRANT,
    ST_XFER_DATA,
    ST_RELEASE
  } state_t;

  function automatic logic is_known_code(input logic [7:0] code);
    return (code == CMD_READY) || (code == CMD_START) ||
           (code == CMD_FULL)  || (code == CMD_DATA);
  endfunction

endpackage

// File: rtl/scan_cmd_rx.sv
// Serial-to-byte receiver for one scanner stream: LSB first, 8 bits per frame,
// frame_vld pulses for one cycle after the eighth bit is captured.
module scan_cmd_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_vld,
  input  logic       bit_in,
  output logic       frame_vld,
  output logic [7:0] frame_byte
);

  logic [6:0] shift_p0;
  logic [2:0] cnt_p0;

  // Bit capture -> completed frame
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_p0   <= '0;
      cnt_p0     <= '0;
      frame_vld  <= 1'b0;
      frame_byte <= '0;
    end else begin
      frame_vld <= 1'b0;
      if (bit_vld) begin
        cnt_p0 <= cnt_p0 + 3'd1;
        if (cnt_p0 == 3'd7) begin
          frame_vld  <= 1'b1;
          frame_byte <= {bit_in, shift_p0};
        end else begin
          shift_p0[cnt_p0] <= bit_in;
        end
      end
    end
  end

endmodule

// File: rtl/scan_transfer_scheduler.sv
// Ping-pong scheduler for two scanners sharing one transfer link: issues
// start/release commands, grants the link and forwards data bytes to the station.
module scan_transfer_scheduler
  import scan_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       startReq,
  input  logic       stopReq,
  input  logic [1:0] scanBitValid,
  input  logic [1:0] scanBit,
  output logic [1:0] localTransferOut0,
  output logic [1:0] localTransferOut1,
  output logic [1:0] readyForTransfer,
  output logic       dataValid,
  output logic [7:0] dataByte,
  output logic       dataSrc,
  output logic       busy,
  output logic       protoErr
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0] fv;
  logic [7:0] fb [2];

  scan_cmd_rx u_rx0 (.clk(clk), .rst(rst), .bit_vld(scanBitValid[0]), .bit_in(scanBit[0]),
                     .frame_vld(fv[0]), .frame_byte(fb[0]));
  scan_cmd_rx u_rx1 (.clk(clk), .rst(rst), .bit_vld(scanBitValid[1]), .bit_in(scanBit[1]),
                     .frame_vld(fv[1]), .frame_byte(fb[1]));

  state_t     state, state_nxt;
  logic       cur, cur_nxt, oth;
  logic [1:0] started, started_nxt;
  logic [1:0] pend, pend_nxt;
  logic       stop_l, stop_nxt;
  logic [7:0] tcnt;
  logic       in_link, timeout;
  logic [1:0] lt_nxt [2];
  logic       dv_nxt, src_nxt, err_nxt;
  logic [7:0] byte_nxt;

  assign oth     = ~cur;
  assign in_link = (state == ST_GRANT) || (state == ST_XFER_DATA);
  assign timeout = in_link && (tcnt == TMO_LAST);
  assign busy    = (state != ST_IDLE);

  always_comb begin
    state_nxt   = state;
    cur_nxt     = cur;
    started_nxt = started;
    pend_nxt    = pend;
    stop_nxt    = stop_l;
    lt_nxt[0]   = LT_NONE;
    lt_nxt[1]   = LT_NONE;
    dv_nxt      = 1'b0;
    byte_nxt    = dataByte;
    src_nxt     = dataSrc;
    err_nxt     = protoErr;

    // The idle scanner may only report "full" (queued) or "80 %" (ignored).
    if (fv[oth]) begin
      if (fb[oth] == CMD_FULL)       pend_nxt[oth] = 1'b1;
      else if (fb[oth] != CMD_READY) err_nxt = 1'b1;
    end
    if (fv[cur] && (state != ST_XFER_DATA) && !is_known_code(fb[cur])) err_nxt = 1'b1;
    if (stopReq && (state != ST_IDLE)) stop_nxt = 1'b1;

    case (state)
      ST_IDLE: begin
        if (startReq) begin
          lt_nxt[cur]      = LT_START;
          started_nxt[cur] = 1'b1;
          state_nxt        = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (fv[cur] && (fb[cur] == CMD_START)) begin
          lt_nxt[oth]      = LT_START;
          started_nxt[oth] = 1'b1;
          state_nxt        = ST_OVERLAP;
        end else if (fv[cur] && (fb[cur] == CMD_FULL)) begin
          state_nxt = ST_GRANT;
        end
      end
      ST_OVERLAP: begin
        if (fv[cur] && (fb[cur] == CMD_FULL)) state_nxt = ST_GRANT;
      end
      ST_GRANT: begin
        if (timeout) begin
          err_nxt   = 1'b1;
          state_nxt = ST_RELEASE;
        end else if (fv[cur] && (fb[cur] == CMD_DATA)) begin
          state_nxt = ST_XFER_DATA;
        end
      end
      ST_XFER_DATA: begin
        if (timeout) begin
          err_nxt   = 1'b1;
          state_nxt = ST_RELEASE;
        end else if (fv[cur]) begin
          dv_nxt    = 1'b1;
          byte_nxt  = fb[cur];
          src_nxt   = cur;
          state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        lt_nxt[cur]      = LT_RELEASE;
        cur_nxt          = oth;
        started_nxt[cur] = 1'b0;
        if (stop_l || !started[oth]) begin
          started_nxt = '0;
          stop_nxt    = 1'b0;
          state_nxt   = ST_IDLE;
        end else if (pend_nxt[oth]) begin
          pend_nxt[oth] = 1'b0;
          state_nxt     = ST_GRANT;
        end else begin
          state_nxt = ST_SCAN;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      cur               <= 1'b0;
      started           <= '0;
      pend              <= '0;
      stop_l            <= 1'b0;
      tcnt              <= '0;
      localTransferOut0 <= LT_NONE;
      localTransferOut1 <= LT_NONE;
      readyForTransfer  <= '0;
      dataValid         <= 1'b0;
      dataByte          <= '0;
      dataSrc           <= 1'b0;
      protoErr          <= 1'b0;
    end else begin
      state             <= state_nxt;
      cur               <= cur_nxt;
      started           <= started_nxt;
      pend              <= pend_nxt;
      stop_l            <= stop_nxt;
      tcnt              <= in_link ? tcnt + 8'd1 : 8'd0;
      localTransferOut0 <= lt_nxt[0];
      localTransferOut1 <= lt_nxt[1];
      readyForTransfer  <= (state_nxt == ST_GRANT) ? (cur_nxt ? 2'b10 : 2'b01) : 2'b00;
      dataValid         <= dv_nxt;
      dataByte          <= byte_nxt;
      dataSrc           <= src_nxt;
      protoErr          <= err_nxt;
    end
  end

endmodule

// File: tb/tb_scan_transfer_scheduler.sv
// Directed bench for scan_transfer_scheduler: ping-pong session, pending full,
// simultaneous frames, timeout, stop handling and mid-frame reset.
module tb_scan_transfer_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       startReq = 1'b0;
  logic       stopReq = 1'b0;
  logic [1:0] scanBitValid = 2'b00;
  logic [1:0] scanBit = 2'b00;
  logic [1:0] localTransferOut0, localTransferOut1, readyForTransfer;
  logic       dataValid, dataSrc, busy, protoErr;
  logic [7:0] dataByte;

  int n_tests = 0;
  int n_fail  = 0;
  int n_st0 = 0, n_st1 = 0, n_rel0 = 0, n_rel1 = 0, n_dv = 0;
  logic [7:0] last_byte = 8'h00;
  logic       last_src  = 1'b0;

  scan_transfer_scheduler #(.TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst(rst), .startReq(startReq), .stopReq(stopReq),
    .scanBitValid(scanBitValid), .scanBit(scanBit),
    .localTransferOut0(localTransferOut0), .localTransferOut1(localTransferOut1),
    .readyForTransfer(readyForTransfer), .dataValid(dataValid), .dataByte(dataByte),
    .dataSrc(dataSrc), .busy(busy), .protoErr(protoErr)
  );

  always #5 clk = ~clk;

  // Pulse monitor on the falling edge
  always @(negedge clk) begin
    if (localTransferOut0 == 2'b01) n_st0++;
    if (localTransferOut1 == 2'b01) n_st1++;
    if (localTransferOut0 == 2'b10) n_rel0++;
    if (localTransferOut1 == 2'b10) n_rel1++;
    if (dataValid) begin
      n_dv++;
      last_byte = dataByte;
      last_src  = dataSrc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    @(negedge clk) startReq = 1'b1;
    @(negedge clk) startReq = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk) stopReq = 1'b1;
    @(negedge clk) stopReq = 1'b0;
  endtask

  task automatic send_byte(input int s, input logic [7:0] b);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      scanBitValid[s] = 1'b1;
      scanBit[s]      = b[k];
    end
    @(negedge clk);
    scanBitValid[s] = 1'b0;
    scanBit[s]      = 1'b0;
  endtask

  task automatic send_two(input logic [7:0] b0, input logic [7:0] b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      scanBitValid = 2'b11;
      scanBit      = {b1[k], b0[k]};
    end
    @(negedge clk);
    scanBitValid = 2'b00;
    scanBit      = 2'b00;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_lt0"},   32'(localTransferOut0), 32'h0);
    chk({tag, "_lt1"},   32'(localTransferOut1), 32'h0);
    chk({tag, "_rdy"},   32'(readyForTransfer),  32'h0);
    chk({tag, "_dv"},    32'(dataValid),         32'h0);
    chk({tag, "_byte"},  32'(dataByte),          32'h0);
    chk({tag, "_src"},   32'(dataSrc),           32'h0);
    chk({tag, "_busy"},  32'(busy),              32'h0);
    chk({tag, "_err"},   32'(protoErr),          32'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_all_zero("reset");

    // Session on scanner 0: start, 90 %, full, header, data
    pulse_start();
    settle(1);
    chk("t1_start0", n_st0, 1);
    chk("t1_busy", 32'(busy), 1);
    send_byte(0, 8'd3);
    settle(2);
    chk("t1_start1", n_st1, 1);
    send_byte(0, 8'd4);
    settle(2);
    chk("t1_grant", 32'(readyForTransfer), 32'h1);
    send_byte(0, 8'd7);
    settle(2);
    chk("t1_xfer_rdy", 32'(readyForTransfer), 32'h0);
    send_byte(0, 8'h09);
    settle(3);
    chk("t1_dv_cnt", n_dv, 1);
    chk("t1_byte", 32'(last_byte), 32'h09);
    chk("t1_src", 32'(last_src), 32'h0);
    chk("t1_rel0", n_rel0, 1);
    chk("t1_busy_scan", 32'(busy), 1);
    chk("t1_err", 32'(protoErr), 0);

    // Scanner 1 now current: start scanner 0, then grant scanner 1
    send_byte(1, 8'd3);
    settle(2);
    chk("t2_start0", n_st0, 2);
    send_byte(1, 8'd4);
    settle(2);
    chk("t2_grant1", 32'(readyForTransfer), 32'h2);
    // Header from current and full from the other in the same cycle
    send_two(8'd4, 8'd7);
    settle(2);
    chk("t3_xfer_rdy", 32'(readyForTransfer), 32'h0);
    chk("t3_err", 32'(protoErr), 0);
    send_byte(1, 8'hA5);
    settle(3);
    chk("t2_dv_cnt", n_dv, 2);
    chk("t2_byte", 32'(last_byte), 32'hA5);
    chk("t2_src", 32'(last_src), 32'h1);
    chk("t2_rel1", n_rel1, 1);
    chk("t2_pend_grant0", 32'(readyForTransfer), 32'h1);
    chk("t2_no_extra_start", n_st0, 2);

    // Scanner 0 granted but never sends a header
    settle(200);
    chk("t4_no_err_yet", 32'(protoErr), 0);
    settle(100);
    chk("t4_err", 32'(protoErr), 1);
    chk("t4_rel0", n_rel0, 2);
    chk("t4_no_dv", n_dv, 2);
    chk("t4_idle", 32'(busy), 0);
    chk("t4_rdy", 32'(readyForTransfer), 32'h0);

    // Stop requested during overlap still completes the transfer
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    pulse_start();
    settle(1);
    chk("t5_start0", n_st0, 3);
    send_byte(0, 8'd3);
    settle(2);
    chk("t5_start1", n_st1, 2);
    pulse_stop();
    settle(1);
    chk("t5_busy_after_stop", 32'(busy), 1);
    send_byte(0, 8'd4);
    settle(2);
    chk("t5_grant", 32'(readyForTransfer), 32'h1);
    send_byte(0, 8'd7);
    send_byte(0, 8'h33);
    settle(3);
    chk("t5_byte", 32'(last_byte), 32'h33);
    chk("t5_dv_cnt", n_dv, 3);
    chk("t5_rel0", n_rel0, 3);
    chk("t5_idle", 32'(busy), 0);
    chk("t5_err", 32'(protoErr), 0);

    // Reset in the middle of a frame discards the partial bits
    pulse_start();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      scanBitValid[0] = 1'b1;
      scanBit[0]      = 1'b1;
    end
    @(negedge clk);
    scanBitValid = 2'b00;
    scanBit      = 2'b00;
    rst          = 1'b1;
    @(negedge clk) rst = 1'b0;
    #1;
    chk_all_zero("t6_rst");
    pulse_start();
    settle(1);
    chk("t6_start0", n_st0, 4);
    send_byte(0, 8'd4);
    settle(2);
    chk("t6_grant", 32'(readyForTransfer), 32'h1);
    chk("t6_err", 32'(protoErr), 0);

    // Informational code from the other scanner, then an unknown code
    send_byte(1, 8'd2);
    settle(2);
    chk("t7_code2_ok", 32'(protoErr), 0);
    send_byte(1, 8'h55);
    settle(2);
    chk("t7_unknown_err", 32'(protoErr), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
